// File: rtl/bank_arbiter_rr_if.sv
// Core-side request/response bus and bank-side handshake for one memory bank arbiter.
// The arbiter takes the slave view; the cores plus the bank storage take the master view.
interface bank_arbiter_rr_if #(
    parameter int N_CORES = 16,
    parameter int ADDR_W  = 12,
    parameter int BANK_W  = 4,
    parameter int DATA_W  = 8
);
    localparam int OFFS_W = ADDR_W - BANK_W;

    logic [N_CORES-1:0]        core_val;
    logic [N_CORES-1:0]        read;
    logic [N_CORES-1:0]        write;
    logic [N_CORES*ADDR_W-1:0] addr_in;
    logic [N_CORES*DATA_W-1:0] data_in;
    logic [N_CORES*DATA_W-1:0] data_out;
    logic [N_CORES-1:0]        finish;

    logic                      b_read;
    logic                      b_write;
    logic [OFFS_W-1:0]         b_addr;
    logic [DATA_W-1:0]         b_data_in;
    logic [DATA_W-1:0]         b_data_out;
    logic                      bank_finish;

    modport slave (
        input  core_val, read, write, addr_in, data_in, b_data_out, bank_finish,
        output data_out, finish, b_read, b_write, b_addr, b_data_in
    );

    modport master (
        output core_val, read, write, addr_in, data_in, b_data_out, bank_finish,
        input  data_out, finish, b_read, b_write, b_addr, b_data_in
    );
endinterface

// File: rtl/bank_arbiter_rr.sv
// Per-bank arbiter: picks one eligible core with skip-ahead round-robin and runs a
// single read/write transaction against the external bank, then pulses finish to that core.
module bank_arbiter_rr #(
    parameter int N_CORES = 16,
    parameter int ADDR_W  = 12,
    parameter int BANK_W  = 4,
    parameter int DATA_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [BANK_W-1:0] bank_n,
    bank_arbiter_rr_if.slave  bus
);
    localparam int IDX_W  = $clog2(N_CORES);
    localparam int OFFS_W = ADDR_W - BANK_W;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   g;

    logic [N_CORES-1:0] elig;
    logic               hit;
    logic [IDX_W-1:0]   g_next;
    logic               sel_wr;
    logic [OFFS_W-1:0]  sel_offs;
    logic [DATA_W-1:0]  sel_data;
    int                 idx;

    // A core whose finish is high this cycle is masked so it cannot be regranted at once.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_CORES; i++) begin
            elig[i] = bus.core_val[i] & (bus.read[i] | bus.write[i]) & ~bus.finish[i] &
                      (bus.addr_in[i*ADDR_W + OFFS_W +: BANK_W] == bank_n);
        end
    end

    always_comb begin
        hit      = 1'b0;
        g_next   = '0;
        sel_wr   = 1'b0;
        sel_offs = '0;
        sel_data = '0;
        idx      = 0;
        for (int k = 0; k < N_CORES; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_CORES) idx = idx - N_CORES;
            if (!hit && elig[IDX_W'(idx)]) begin
                hit      = 1'b1;
                g_next   = IDX_W'(idx);
                sel_wr   = bus.write[IDX_W'(idx)];
                sel_offs = bus.addr_in[idx*ADDR_W +: OFFS_W];
                sel_data = bus.data_in[idx*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= '0;
            g             <= '0;
            bus.finish    <= '0;
            bus.data_out  <= '0;
            bus.b_read    <= 1'b0;
            bus.b_write   <= 1'b0;
            bus.b_addr    <= '0;
            bus.b_data_in <= '0;
        end else begin
            bus.finish <= '0;
            case (state)
                IDLE: begin
                    if (hit) begin
                        g             <= g_next;
                        bus.b_write   <= sel_wr;
                        bus.b_read    <= ~sel_wr;
                        bus.b_addr    <= sel_offs;
                        bus.b_data_in <= sel_data;
                        state         <= BUSY;
                    end
                end
                BUSY: begin
                    // Bank strobes and operands stay frozen until the bank reports completion.
                    if (bus.bank_finish) begin
                        bus.finish[g] <= 1'b1;
                        if (bus.b_read) bus.data_out[int'(g)*DATA_W +: DATA_W] <= bus.b_data_out;
                        ptr         <= (g == IDX_W'(N_CORES-1)) ? '0 : g + 1'b1;
                        bus.b_read  <= 1'b0;
                        bus.b_write <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bank_arbiter_rr.sv
// Directed bench for bank_arbiter_rr: reset, single read, bank mismatch, round-robin order,
// slow bank write, held request masking and reset during a transaction.
module tb_bank_arbiter_rr;
    localparam int N  = 16;
    localparam int AW = 12;
    localparam int BW = 4;
    localparam int DW = 8;

    logic          clock;
    logic          reset;
    logic [BW-1:0] bank_n;

    int checks;
    int failures;

    int          served [16];
    int          n_served;
    logic        multi_hot;
    logic [N-1:0] hold_mask;
    logic [N*DW-1:0] mask;

    bank_arbiter_rr_if #(.N_CORES(N), .ADDR_W(AW), .BANK_W(BW), .DATA_W(DW)) bus ();

    bank_arbiter_rr #(.N_CORES(N), .ADDR_W(AW), .BANK_W(BW), .DATA_W(DW)) dut (
        .clock  (clock),
        .reset  (reset),
        .bank_n (bank_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_reqs();
        bus.core_val = '0;
        bus.read     = '0;
        bus.write    = '0;
        bus.addr_in  = '0;
        bus.data_in  = '0;
    endtask

    task automatic set_req(input int i, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.core_val[i]          = 1'b1;
        bus.read[i]              = rd;
        bus.write[i]             = wr;
        bus.addr_in[i*AW +: AW]  = a;
        bus.data_in[i*DW +: DW]  = d;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        clear_reqs();
        bus.bank_finish = 1'b0;
        bus.b_data_out  = '0;
        hold_mask       = '0;
        tick();
        reset = 1'b0;
    endtask

    // One-cycle bank model: records served cores, drops non-held requests on finish.
    task automatic collect(input int want, input int max_cycles, input logic [DW-1:0] rdata);
        n_served  = 0;
        multi_hot = 1'b0;
        for (int c = 0; c < max_cycles && n_served < want; c++) begin
            tick();
            if (bus.finish != '0) begin
                if (!$onehot(bus.finish)) multi_hot = 1'b1;
                for (int i = 0; i < N; i++) begin
                    if (bus.finish[i] && n_served < 16) begin
                        served[n_served] = i;
                        n_served++;
                        if (!hold_mask[i]) bus.core_val[i] = 1'b0;
                    end
                end
            end
            bus.b_data_out  = rdata;
            bus.bank_finish = bus.b_read | bus.b_write;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_reqs();
        bus.bank_finish = 1'b0;
        bus.b_data_out  = '0;
        repeat (3) tick();
        checks++; if (bus.data_out !== '0) begin failures++; $display("FAIL reset_data_out got=%h exp=0", bus.data_out); end
        checks++; if (bus.finish !== '0) begin failures++; $display("FAIL reset_finish got=%h exp=0", bus.finish); end
        checks++; if (bus.b_read !== 1'b0 || bus.b_write !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%b%b exp=00", bus.b_read, bus.b_write); end
        checks++; if (bus.b_addr !== '0 || bus.b_data_in !== '0) begin failures++; $display("FAIL reset_bregs got=%h/%h exp=0/0", bus.b_addr, bus.b_data_in); end
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        set_req(5, 1'b1, 1'b0, 12'h3A7, 8'h00);
        tick();
        checks++; if (bus.b_read !== 1'b1 || bus.b_write !== 1'b0) begin failures++; $display("FAIL rd_strobe got=%b%b exp=10", bus.b_read, bus.b_write); end
        checks++; if (bus.b_addr !== 8'hA7) begin failures++; $display("FAIL rd_addr got=%h exp=a7", bus.b_addr); end
        bus.bank_finish = 1'b1;
        bus.b_data_out  = 8'h5C;
        tick();
        checks++; if (bus.finish !== 16'h0020) begin failures++; $display("FAIL rd_finish got=%h exp=0020", bus.finish); end
        checks++; if (bus.data_out[47:40] !== 8'h5C) begin failures++; $display("FAIL rd_data got=%h exp=5c", bus.data_out[47:40]); end
        mask = '1;
        mask[47:40] = '0;
        checks++; if ((bus.data_out & mask) !== '0) begin failures++; $display("FAIL rd_other_slices got=%h exp=0", bus.data_out & mask); end
        checks++; if (bus.b_read !== 1'b0) begin failures++; $display("FAIL rd_strobe_drop got=%b exp=0", bus.b_read); end
        bus.core_val[5] = 1'b0;
        bus.bank_finish = 1'b0;
        tick();
        checks++; if (bus.finish !== '0) begin failures++; $display("FAIL rd_finish_pulse got=%h exp=0", bus.finish); end
    endtask

    task automatic test_bank_mismatch();
        do_reset();
        set_req(2, 1'b1, 1'b0, 12'h4A7, 8'h00);
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (bus.b_read !== 1'b0 || bus.b_write !== 1'b0 || bus.finish !== '0) begin
                failures++;
                $display("FAIL mismatch_c%0d got=%b%b/%h exp=00/0", c, bus.b_read, bus.b_write, bus.finish);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        set_req(1, 1'b1, 1'b0, 12'h301, 8'h00);
        set_req(7, 1'b1, 1'b0, 12'h307, 8'h00);
        set_req(14, 1'b1, 1'b0, 12'h30E, 8'h00);
        collect(3, 60, 8'h11);
        checks++; if (n_served != 3 || served[0] != 1 || served[1] != 7 || served[2] != 14) begin
            failures++; $display("FAIL rr_ptr0 got=%0d:%0d,%0d,%0d exp=3:1,7,14", n_served, served[0], served[1], served[2]); end
        checks++; if (multi_hot !== 1'b0) begin failures++; $display("FAIL rr_onehot got=%b exp=0", multi_hot); end
        checks++; if (bus.data_out[14*DW +: DW] !== 8'h11) begin failures++; $display("FAIL rr_data14 got=%h exp=11", bus.data_out[14*DW +: DW]); end

        do_reset();
        set_req(7, 1'b1, 1'b0, 12'h307, 8'h00);
        collect(1, 20, 8'h22);
        set_req(1, 1'b1, 1'b0, 12'h301, 8'h00);
        set_req(7, 1'b1, 1'b0, 12'h307, 8'h00);
        set_req(14, 1'b1, 1'b0, 12'h30E, 8'h00);
        collect(3, 60, 8'h22);
        checks++; if (n_served != 3 || served[0] != 14 || served[1] != 1 || served[2] != 7) begin
            failures++; $display("FAIL rr_ptr8 got=%0d:%0d,%0d,%0d exp=3:14,1,7", n_served, served[0], served[1], served[2]); end
    endtask

    task automatic test_slow_write();
        do_reset();
        set_req(0, 1'b1, 1'b1, 12'h312, 8'hA5);
        tick();
        // Core changes everything while busy; the latched transaction must not move.
        bus.core_val[0]   = 1'b0;
        bus.addr_in[11:0] = 12'h000;
        bus.data_in[7:0]  = 8'h00;
        bus.b_data_out    = 8'hEE;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (bus.b_write !== 1'b1 || bus.b_read !== 1'b0 || bus.b_addr !== 8'h12 ||
                bus.b_data_in !== 8'hA5 || bus.finish !== '0) begin
                failures++;
                $display("FAIL wr_hold_c%0d got=%b%b/%h/%h/%h exp=01/12/a5/0", c, bus.b_read, bus.b_write,
                         bus.b_addr, bus.b_data_in, bus.finish);
            end
            if (c == 4) bus.bank_finish = 1'b1;
            tick();
        end
        checks++; if (bus.finish !== 16'h0001) begin failures++; $display("FAIL wr_finish got=%h exp=0001", bus.finish); end
        checks++; if (bus.data_out !== '0) begin failures++; $display("FAIL wr_data_out got=%h exp=0", bus.data_out); end
        checks++; if (bus.b_write !== 1'b0) begin failures++; $display("FAIL wr_strobe_drop got=%b exp=0", bus.b_write); end
        bus.bank_finish = 1'b0;
        tick();
        checks++; if (bus.finish !== '0) begin failures++; $display("FAIL wr_finish_pulse got=%h exp=0", bus.finish); end
    endtask

    task automatic test_held_request();
        do_reset();
        hold_mask = 16'h0200;
        set_req(9, 1'b1, 1'b0, 12'h309, 8'h00);
        set_req(10, 1'b1, 1'b0, 12'h30A, 8'h00);
        collect(3, 60, 8'h44);
        checks++; if (n_served != 3 || served[0] != 9 || served[1] != 10 || served[2] != 9) begin
            failures++; $display("FAIL held_order got=%0d:%0d,%0d,%0d exp=3:9,10,9", n_served, served[0], served[1], served[2]); end
        tick();
        checks++; if (bus.b_read !== 1'b0 || bus.finish !== '0) begin failures++; $display("FAIL held_mask got=%b/%h exp=0/0", bus.b_read, bus.finish); end
        tick();
        checks++; if (bus.b_read !== 1'b1) begin failures++; $display("FAIL held_regrant got=%b exp=1", bus.b_read); end
    endtask

    task automatic test_reset_busy();
        do_reset();
        set_req(12, 1'b1, 1'b0, 12'h30C, 8'h00);
        collect(1, 20, 8'h33);
        checks++; if (bus.data_out[12*DW +: DW] !== 8'h33) begin failures++; $display("FAIL rb_pre_data got=%h exp=33", bus.data_out[12*DW +: DW]); end
        set_req(5, 1'b1, 1'b0, 12'h3A7, 8'h99);
        tick();
        checks++; if (bus.b_read !== 1'b1 || bus.b_addr !== 8'hA7 || bus.b_data_in !== 8'h99) begin
            failures++; $display("FAIL rb_grant got=%b/%h/%h exp=1/a7/99", bus.b_read, bus.b_addr, bus.b_data_in); end
        reset           = 1'b1;
        bus.bank_finish = 1'b1;
        bus.b_data_out  = 8'h77;
        tick();
        checks++; if (bus.finish !== '0 || bus.b_read !== 1'b0 || bus.b_write !== 1'b0) begin
            failures++; $display("FAIL rb_ctrl got=%h/%b%b exp=0/00", bus.finish, bus.b_read, bus.b_write); end
        checks++; if (bus.b_addr !== '0 || bus.b_data_in !== '0 || bus.data_out !== '0) begin
            failures++; $display("FAIL rb_data got=%h/%h/%h exp=0/0/0", bus.b_addr, bus.b_data_in, bus.data_out); end
        reset           = 1'b0;
        bus.bank_finish = 1'b0;
        clear_reqs();
        set_req(2, 1'b1, 1'b0, 12'h302, 8'h00);
        set_req(14, 1'b1, 1'b0, 12'h30E, 8'h00);
        collect(1, 20, 8'h55);
        checks++; if (n_served != 1 || served[0] != 2) begin failures++; $display("FAIL rb_ptr got=%0d:%0d exp=1:2", n_served, served[0]); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        bank_n    = 4'd3;
        hold_mask = '0;
        n_served  = 0;
        multi_hot = 1'b0;
        mask      = '0;
        for (int i = 0; i < 16; i++) served[i] = -1;
        clear_reqs();
        bus.bank_finish = 1'b0;
        bus.b_data_out  = '0;

        test_reset();
        test_single_read();
        test_bank_mismatch();
        test_round_robin();
        test_slow_write();
        test_held_request();
        test_reset_busy();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
